// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
//   Eight-source interrupt controller with fixed priority (bit 0 highest),
//   edge-detected request latching, a mask register and a single-level
//   request/acknowledge/end-of-interrupt handshake with the CPU.
//
// Parameters
//   VBASE        base address of the interrupt vector table
//
// Ports
//   clk_i        rising-edge system clock
//   clrn_i       asynchronous active-low reset
//   irq_i[7:0]   level request lines, synchronous to clk_i
//   inta_i       interrupt acknowledge from the CPU
//   eoi_i        end-of-interrupt pulse from the CPU
//   mask_we_i    mask register write enable
//   mask_wd_i    mask write data (1 masks the source)
//   intr_o       interrupt request to the CPU
//   ivec_o       handler address, VBASE + 4*id
//   id_o         index of the source last acknowledged
//   pending_o    pending register
//   mask_o       mask register
//   busy_o       high while a source is in service
// -----------------------------------------------------------------------------
module intr_ctrl #(
   parameter logic [31:0] VBASE = 32'h0000_0008
) (
   input  logic        clk_i,
   input  logic        clrn_i,
   input  logic [7:0]  irq_i,
   input  logic        inta_i,
   input  logic        eoi_i,
   input  logic        mask_we_i,
   input  logic [7:0]  mask_wd_i,
   output logic        intr_o,
   output logic [31:0] ivec_o,
   output logic [2:0]  id_o,
   output logic [7:0]  pending_o,
   output logic [7:0]  mask_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  irq_q;
   logic [7:0]  pending_q, pending_d;
   logic [7:0]  mask_q, mask_d;
   logic [2:0]  id_q, id_d;

   logic [7:0]  rise;
   logic [7:0]  active;
   logic        any_active;
   logic [2:0]  lowest_idx;
   logic        ack;
   logic [7:0]  ack_clr;

   assign rise       = irq_i & ~irq_q;
   assign active     = pending_q & ~mask_q;
   assign any_active = |active;

   // Fixed-priority encoder: scanning downward lets the lowest index win.
   always_comb begin
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) begin
            lowest_idx = 3'(i);
         end
      end
   end

   // An acknowledge only takes effect in REQ while something is still
   // eligible; a request withdrawn by masking beats a simultaneous Inta.
   assign ack     = (state_q == ST_REQ) && inta_i && any_active;
   assign ack_clr = ack ? (8'h01 << lowest_idx) : 8'h00;

   // Clearing first and OR-ing the new edge afterwards makes set win.
   assign pending_d = (pending_q & ~ack_clr) | rise;
   assign mask_d    = mask_we_i ? mask_wd_i : mask_q;
   assign id_d      = ack ? lowest_idx : id_q;

   // State register and datapath registers
   always_ff @(posedge clk_i or negedge clrn_i) begin
      if (!clrn_i) begin
         state_q   <= ST_IDLE;
         irq_q     <= 8'h00;
         pending_q <= 8'h00;
         mask_q    <= 8'hFF;
         id_q      <= 3'd0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_i;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         id_q      <= id_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_active) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (!any_active)  state_d = ST_IDLE;
            else if (inta_i)  state_d = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (eoi_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      intr_o = (state_q == ST_REQ);
      busy_o = (state_q == ST_SERVICE);
   end

   assign id_o      = id_q;
   assign ivec_o    = VBASE + {27'd0, id_q, 2'b00};
   assign pending_o = pending_q;
   assign mask_o    = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
//   Directed bench for intr_ctrl. A behavioural model tracks the expected
//   register contents and handshake phase; a compare process checks every
//   output on each falling edge, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

   localparam logic [31:0] VBASE = 32'h0000_0008;

   logic        clk = 1'b0;
   logic        clrn;
   logic [7:0]  irq;
   logic        inta;
   logic        eoi;
   logic        mask_we;
   logic [7:0]  mask_wd;
   logic        intr;
   logic [31:0] ivec;
   logic [2:0]  id;
   logic [7:0]  pending;
   logic [7:0]  mask;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   intr_ctrl #(.VBASE(VBASE)) dut (
      .clk_i     (clk),
      .clrn_i    (clrn),
      .irq_i     (irq),
      .inta_i    (inta),
      .eoi_i     (eoi),
      .mask_we_i (mask_we),
      .mask_wd_i (mask_wd),
      .intr_o    (intr),
      .ivec_o    (ivec),
      .id_o      (id),
      .pending_o (pending),
      .mask_o    (mask),
      .busy_o    (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_prev, m_pend, m_mask;
   logic [2:0] m_id;
   bit         m_req, m_svc;
   logic [7:0] m_rise, m_elig;

   assign m_rise = irq & ~m_prev;
   assign m_elig = m_pend & ~m_mask;

   function automatic int lowest(input logic [7:0] v);
      int r = -1;
      for (int i = 0; i < 8; i++)
         if (v[i] && r < 0) r = i;
      return r;
   endfunction

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         m_prev <= 8'h00; m_pend <= 8'h00; m_mask <= 8'hFF;
         m_id <= 3'd0; m_req <= 1'b0; m_svc <= 1'b0;
      end else begin
         m_prev <= irq;
         if (mask_we) m_mask <= mask_wd;
         m_pend <= m_pend | m_rise;
         if (m_svc) begin
            if (eoi) m_svc <= 1'b0;
         end else if (m_req) begin
            if (m_elig == 8'h00) begin
               m_req <= 1'b0;
            end else if (inta) begin
               m_req <= 1'b0;
               m_svc <= 1'b1;
               m_id  <= 3'(lowest(m_elig));
               m_pend <= (m_pend & ~(8'h01 << lowest(m_elig))) | m_rise;
            end
         end else begin
            m_req <= (m_elig != 8'h00);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("model_intr",    {31'd0, intr}, {31'd0, m_req});
      chk("model_busy",    {31'd0, busy}, {31'd0, m_svc});
      chk("model_id",      {29'd0, id},   {29'd0, m_id});
      chk("model_ivec",    ivec,          VBASE + 32'(4 * int'(m_id)));
      chk("model_pending", {24'd0, pending}, {24'd0, m_pend});
      chk("model_mask",    {24'd0, mask},    {24'd0, m_mask});
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_mask(input logic [7:0] v);
      mask_we = 1'b1; mask_wd = v;
      tick();
      mask_we = 1'b0;
      $display("mask write %h", v);
   endtask

   task automatic pulse_inta();
      inta = 1'b1; tick(); inta = 1'b0;
      $display("inta: id=%0d ivec=%h pending=%h busy=%b", id, ivec, pending, busy);
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1; tick(); eoi = 1'b0;
      $display("eoi: busy=%b intr=%b", busy, intr);
   endtask

   initial begin
      clrn = 1'b0; irq = 8'h00; inta = 1'b0; eoi = 1'b0;
      mask_we = 1'b0; mask_wd = 8'h00;
      @(negedge clk);
      tick();
      chk("rst_intr",    {31'd0, intr}, 32'd0);
      chk("rst_busy",    {31'd0, busy}, 32'd0);
      chk("rst_ivec",    ivec, 32'h8);
      chk("rst_mask",    {24'd0, mask}, 32'hFF);
      chk("rst_pending", {24'd0, pending}, 32'h0);
      chk("rst_id",      {29'd0, id}, 32'd0);
      clrn = 1'b1;

      // basic request
      write_mask(8'h00);
      chk("basic_mask", {24'd0, mask}, 32'h00);
      irq = 8'h08; tick();
      chk("basic_pend1", {24'd0, pending}, 32'h08);
      chk("basic_intr1", {31'd0, intr}, 32'd0);
      tick();
      chk("basic_intr2", {31'd0, intr}, 32'd1);
      pulse_inta();
      chk("basic_id",   {29'd0, id}, 32'd3);
      chk("basic_ivec", ivec, 32'h14);
      chk("basic_pend", {24'd0, pending}, 32'h00);
      chk("basic_intr", {31'd0, intr}, 32'd0);
      chk("basic_busy", {31'd0, busy}, 32'd1);
      irq = 8'h00;
      pulse_eoi();
      chk("basic_eoi_busy", {31'd0, busy}, 32'd0);

      // priority
      irq = 8'h24; tick(); irq = 8'h00; tick();
      chk("prio_intr", {31'd0, intr}, 32'd1);
      pulse_inta();
      chk("prio_id1",   {29'd0, id}, 32'd2);
      chk("prio_pend1", {24'd0, pending}, 32'h20);
      pulse_eoi();
      chk("prio_idle_intr", {31'd0, intr}, 32'd0);
      tick();
      chk("prio_reintr", {31'd0, intr}, 32'd1);
      pulse_inta();
      chk("prio_id2", {29'd0, id}, 32'd5);
      chk("prio_ivec2", ivec, 32'h1C);
      pulse_eoi();

      // masked source
      write_mask(8'hFF);
      irq = 8'h01; tick(); irq = 8'h00;
      chk("mask_pend", {24'd0, pending}, 32'h01);
      tick(); tick();
      chk("mask_nointr", {31'd0, intr}, 32'd0);
      write_mask(8'hFE);
      chk("mask_wr_intr0", {31'd0, intr}, 32'd0);
      tick();
      chk("mask_wr_intr1", {31'd0, intr}, 32'd1);
      pulse_inta();
      chk("mask_id", {29'd0, id}, 32'd0);
      pulse_eoi();

      // mask withdrawal
      write_mask(8'h00);
      irq = 8'h10; tick(); irq = 8'h00; tick();
      chk("wd_req", {31'd0, intr}, 32'd1);
      write_mask(8'h10);
      chk("wd_still_req", {31'd0, intr}, 32'd1);
      tick();
      chk("wd_intr", {31'd0, intr}, 32'd0);
      chk("wd_pend", {24'd0, pending}, 32'h10);
      write_mask(8'h00);
      tick();
      pulse_inta();
      chk("wd_id4_ivec", ivec, 32'h18);
      pulse_eoi();

      // collision: re-rise during acknowledge
      irq = 8'h02; tick(); irq = 8'h00; tick();
      chk("col_req", {31'd0, intr}, 32'd1);
      irq = 8'h02; pulse_inta();
      chk("col_pend", {24'd0, pending}, 32'h02);
      chk("col_id",   {29'd0, id}, 32'd1);
      chk("col_busy", {31'd0, busy}, 32'd1);
      pulse_inta();
      chk("col_svc_busy", {31'd0, busy}, 32'd1);
      chk("col_svc_pend", {24'd0, pending}, 32'h02);
      pulse_eoi();
      tick();
      chk("col_nonest_intr", {31'd0, intr}, 32'd1);
      pulse_inta();
      chk("col_pend_clr", {24'd0, pending}, 32'h00);
      irq = 8'h00;
      pulse_eoi();

      // masked away while Inta arrives: withdrawal wins, Id unchanged
      irq = 8'h80; tick(); irq = 8'h00; tick();
      write_mask(8'h80);
      chk("prec_req", {31'd0, intr}, 32'd1);
      pulse_inta();
      chk("prec_intr", {31'd0, intr}, 32'd0);
      chk("prec_busy", {31'd0, busy}, 32'd0);
      chk("prec_id",   {29'd0, id}, 32'd1);
      chk("prec_pend", {24'd0, pending}, 32'h80);
      write_mask(8'h00);
      tick();
      pulse_inta();
      chk("prec_id7", {29'd0, id}, 32'd7);
      pulse_eoi();

      // reset mid-service
      irq = 8'h40; tick(); irq = 8'h00; tick();
      pulse_inta();
      chk("rms_id", {29'd0, id}, 32'd6);
      chk("rms_busy", {31'd0, busy}, 32'd1);
      #2 clrn = 1'b0;
      #1;
      chk("rms_intr", {31'd0, intr}, 32'd0);
      chk("rms_busy0", {31'd0, busy}, 32'd0);
      chk("rms_id0", {29'd0, id}, 32'd0);
      chk("rms_ivec", ivec, 32'h8);
      chk("rms_mask", {24'd0, mask}, 32'hFF);
      $display("async reset: intr=%b busy=%b id=%0d ivec=%h mask=%h", intr, busy, id, ivec, mask);
      @(negedge clk);
      irq = 8'h01;
      tick();
      clrn = 1'b1;
      tick();
      chk("rel_pend", {24'd0, pending}, 32'h01);
      chk("rel_intr", {31'd0, intr}, 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
